// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int JIDX_MSB   = 25;
  localparam int IMM_MSB    = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_TRAP  = 2'd3
  } fetch_state_e;

  // Branch offset: sign-extended 16-bit word offset turned into a byte offset.
  function automatic logic [INSTR_W-1:0] sext_imm_x4(input logic [IMM_MSB:0] imm);
    return {{14{imm[IMM_MSB]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC selection: pc+4, branch/jump targets, JR > Jump > Branch priority.
// With FETCH_ALIGN_CHECK_EN the raw target is passed through so the caller can trap on it.
module fetch_unit_next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [INSTR_W-1:0]  pc_i,
  input  logic [JIDX_MSB:0]   instr_idx_i,
  input  logic                jump_i,
  input  logic                branch_i,
  input  logic                jr_i,
  input  logic                branch_cond_i,
  input  logic [INSTR_W-1:0]  rs_data_i,
  output logic [INSTR_W-1:0]  pc_plus4_o,
  output logic [INSTR_W-1:0]  next_pc_o
);

  logic [INSTR_W-1:0] br_target;
  logic [INSTR_W-1:0] j_target;
  logic [INSTR_W-1:0] sel;

  assign pc_plus4_o = pc_i + 32'd4;
  assign br_target  = pc_plus4_o + sext_imm_x4(instr_idx_i[IMM_MSB:0]);
  assign j_target   = {pc_plus4_o[31:28], instr_idx_i, 2'b00};

  always_comb begin
    sel = pc_plus4_o;
    if (jr_i) begin
      sel = rs_data_i;
    end else if (jump_i) begin
      sel = j_target;
    end else if (branch_i && branch_cond_i) begin
      sel = br_target;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign next_pc_o = sel;
`else
  // Only JR can produce a misaligned target; silently word-align it.
  assign next_pc_o = sel & 32'hFFFF_FFFC;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Fetch / PC-sequencing stage: req/ack instruction fetch, hold for execute, PC update.
// Optional misaligned-target trap enabled by FETCH_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | one cycle after reset release
// FETCH | imem_req high at pc, waiting for imem_ack
// EXEC  | instr valid, waiting for exec_done
// TRAP  | misaligned next_pc seen, fault held until reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        JR,
  input  logic        SavePC,
  input  logic        branch_cond,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        fault
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] next_pc;
  logic [INSTR_W-1:0] pc_plus4;
  logic               pc_misaligned;
  logic               save_pc_unused;

  // link_addr is always driven; SavePC only gates the register-file write in the core.
  assign save_pc_unused = SavePC;

  fetch_unit_next_pc_sel u_next_pc_sel (
    .pc_i          (pc_q),
    .instr_idx_i   (instr_q[JIDX_MSB:0]),
    .jump_i        (Jump),
    .branch_i      (Branch),
    .jr_i          (JR),
    .branch_cond_i (branch_cond),
    .rs_data_i     (rs_data),
    .pc_plus4_o    (pc_plus4),
    .next_pc_o     (next_pc)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  assign pc_misaligned = |next_pc[1:0];
  assign fault         = (state_q == ST_TRAP);
`else
  assign pc_misaligned = 1'b0;
  assign fault         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          if (pc_misaligned) begin
            state_d = ST_TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign link_addr = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, wait-state/reset corners,
// and randomized instruction streams against a behavioural next-PC model.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic        Jump = 1'b0, Branch = 1'b0, JR = 1'b0, SavePC = 1'b0, branch_cond = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .Jump        (Jump),
    .Branch      (Branch),
    .JR          (JR),
    .SavePC      (SavePC),
    .branch_cond (branch_cond),
    .rs_data     (rs_data),
    .pc          (pc),
    .link_addr   (link_addr),
    .fault       (fault)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_pc;

  typedef struct {
    bit          jr, j, br, bc;
    logic [31:0] rs;
    logic [31:0] iw;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next PC from the architectural rules, using plain integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] iw,
                                           input bit jr, input bit j, input bit br, input bit bc,
                                           input logic [31:0] rs);
    logic [31:0] seq, tgt;
    int          off;
    seq = cur + 32'd4;
    off = 4 * int'($signed(iw[15:0]));
    if (jr)            tgt = rs;
    else if (j)        tgt = (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 4);
    else if (br && bc) tgt = seq + 32'(off);
    else               tgt = seq;
`ifndef FETCH_ALIGN_CHECK_EN
    tgt = tgt - (tgt % 4);
`endif
    return tgt;
  endfunction

  task automatic set_ctrl(input bit jr, input bit j, input bit br, input bit bc, input logic [31:0] rs);
    JR = jr; Jump = j; Branch = br; branch_cond = bc; rs_data = rs;
    SavePC = 1'($urandom);
  endtask

  // Entered at a negedge with the DUT in FETCH at m_pc; leaves at the negedge after exec_done.
  task automatic run_instr(input int ws, input int xd, input logic [31:0] iw,
                           input bit jr, input bit j, input bit br, input bit bc,
                           input logic [31:0] rs, input bit noise);
    logic [31:0] prev_instr;
    prev_instr = instr;
    for (int w = 0; w < ws; w++) begin
      chk("fetch_req_wait", imem_req, 1);
      chk("fetch_addr_stable", imem_addr, m_pc);
      chk("instr_hold_wait", instr, prev_instr);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      exec_done  = noise ? 1'($urandom) : 1'b0;
      set_ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      @(negedge clk);
    end
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_no_valid", instr_valid, 0);
    imem_ack   = 1'b1;
    imem_rdata = iw;
    exec_done  = noise ? 1'($urandom) : 1'b0;
    @(negedge clk);
    imem_ack  = 1'b0;
    exec_done = 1'b0;
    for (int d = 0; d <= xd; d++) begin
      chk("exec_valid", instr_valid, 1);
      chk("exec_req", imem_req, 0);
      chk("exec_instr", instr, iw);
      chk("link_addr", link_addr, m_pc + 32'd4);
      chk("exec_pc", pc, m_pc);
      if (d == xd) begin
        exec_done = 1'b1;
        set_ctrl(jr, j, br, bc, rs);
      end else begin
        exec_done  = 1'b0;
        imem_ack   = noise ? 1'($urandom) : 1'b0;
        imem_rdata = $urandom;
        set_ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      end
      @(negedge clk);
    end
    exec_done = 1'b0;
    imem_ack  = 1'b0;
    set_ctrl(0, 0, 0, 0, 32'h0);
  endtask

  task automatic release_reset();
    rstn     = 1'b1;
    imem_ack = 1'b0;
    #1;
    chk("idle_no_req", imem_req, 0);
    chk("idle_no_valid", instr_valid, 0);
    @(negedge clk);
    m_pc = RPC;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_pc"}, pc, RPC);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_fault"}, fault, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] iw, rs, exp, held_pc;
    bit jr, j, br, bc;

    //             jr j  br bc rs            iw            exp_pc
    vt[0]  = '{0, 0, 0, 0, 32'h0,        32'h0000_0000, 32'h0000_0044};
    vt[1]  = '{0, 0, 0, 0, 32'h0,        32'h1234_5678, 32'h0000_0048};
    vt[2]  = '{1, 0, 0, 0, 32'h100,      32'h0000_0000, 32'h0000_0100};
    vt[3]  = '{0, 0, 1, 1, 32'h0,        32'h1000_FFFE, 32'h0000_00FC};
    vt[4]  = '{1, 0, 0, 0, 32'h100,      32'h0000_0000, 32'h0000_0100};
    vt[5]  = '{0, 0, 1, 0, 32'h0,        32'h1000_FFFE, 32'h0000_0104};
    vt[6]  = '{1, 0, 0, 0, 32'h1000_0000, 32'h0,        32'h1000_0000};
    vt[7]  = '{0, 1, 0, 0, 32'h0,        32'h0800_0010, 32'h1000_0040};
    vt[8]  = '{1, 1, 0, 0, 32'h2000,     32'h0800_0010, 32'h0000_2000};
    vt[9]  = '{1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,        32'hFFFF_FFFC};
    vt[10] = '{0, 0, 0, 0, 32'h0,        32'h0,         32'h0000_0000};
    vt[11] = '{0, 0, 1, 1, 32'h0,        32'h1000_7FFF, 32'h0002_0000};

    // Reset state, with a stray ack that must be ignored.
    imem_ack = 1'b1;
    @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_link", link_addr, RPC + 32'd4);
    release_reset();

    foreach (vt[i]) begin
      run_instr(0, 0, vt[i].iw, vt[i].jr, vt[i].j, vt[i].br, vt[i].bc, vt[i].rs, 0);
      chk("tbl_pc", pc, vt[i].exp_pc);
      chk("tbl_fault", fault, 0);
      m_pc = vt[i].exp_pc;
    end

    // Three wait states with stray exec_done during FETCH.
    iw = 32'h2108_0004;
    run_instr(3, 0, iw, 0, 0, 0, 0, 32'h0, 1);
    m_pc = ref_next(m_pc, iw, 0, 0, 0, 0, 32'h0);
    chk("ws_pc", pc, m_pc);

    // Randomized stream.
    for (int k = 0; k < 150; k++) begin
      iw = $urandom;
      jr = ($urandom_range(0, 3) == 0);
      j  = 1'($urandom);
      br = 1'($urandom);
      bc = 1'($urandom);
      rs = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      rs = rs & 32'hFFFF_FFFC;
`endif
      run_instr($urandom_range(0, 3), $urandom_range(0, 2), iw, jr, j, br, bc, rs, 1);
      m_pc = ref_next(m_pc, iw, jr, j, br, bc, rs);
      chk("rand_pc", pc, m_pc);
    end

    // Reset during FETCH with an ack pending.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2 rstn = 1'b0;
    #1 chk_reset_vals("rst_fetch");
    @(negedge clk);
    chk("rst_fetch_ack_ignored", instr, 0);
    release_reset();
    run_instr(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
    chk("rst_fetch_restart", pc, RPC + 32'd4);
    m_pc = RPC + 32'd4;

    // Reset during EXEC.
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("pre_rst_exec_valid", instr_valid, 1);
    #2 rstn = 1'b0;
    #1 chk_reset_vals("rst_exec");
    @(negedge clk);
    release_reset();
    chk("rst_exec_restart_addr", imem_addr, RPC);

    // Misaligned JR target.
    held_pc = m_pc;
    run_instr(0, 0, 32'h0, 1, 0, 0, 0, 32'h2002, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int c = 0; c < 3; c++) begin
      chk("trap_fault", fault, 1);
      chk("trap_no_req", imem_req, 0);
      chk("trap_pc_held", pc, held_pc);
      imem_ack = 1'b1;
      @(negedge clk);
    end
    imem_ack = 1'b0;
`else
    chk("misalign_pc", pc, 32'h2000);
    chk("misalign_fault", fault, 0);
    m_pc = 32'h2000;
    run_instr(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
    chk("misalign_next", pc, 32'h2004);
    chk("misalign_held_differs", (held_pc != pc) ? 32'd1 : 32'd0, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
